tisc_wbvio_master: RTL and testbench

//  Single-transaction WISHBONE master driving the interconnect's wbvio slave port. Accepts one

---
 rtl/tisc_wbvio_master.sv | 147 ++++++++++++++
 tb/tb_tisc_wbvio_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tisc_wbvio_master.sv
// Single-transaction WISHBONE master for the wbvio slave port.
// Runs one classic cycle per command with bus timeout and bounded retry.
module tisc_wbvio_master #(
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        go_i,
    input  logic        cmd_we_i,
    input  logic [20:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [31:0] rdata_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [20:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    input  logic [31:0] dat_i
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);

    localparam logic [1:0] ST_ACK = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_RTY = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [RW-1:0] retry_cnt, retry_n;
    logic [1:0]    status_n;
    logic [31:0]   rdata_n;
    logic          latch;
    logic          we_r;
    logic          we_n;

    always_comb begin
        state_n  = state;
        tmo_n    = tmo_cnt;
        retry_n  = retry_cnt;
        status_n = status_o;
        rdata_n  = rdata_o;
        latch    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (go_i) begin
                    latch   = 1'b1;
                    tmo_n   = '0;
                    retry_n = '0;
                    state_n = BUS;
                end
            end
            BUS: begin
                if (ack_i) begin
                    if (!we_r) begin
                        rdata_n = dat_i;
                    end
                    status_n = ST_ACK;
                    state_n  = DONE;
                end else if (err_i) begin
                    status_n = ST_ERR;
                    state_n  = DONE;
                end else if (rty_i) begin
                    if (retry_cnt == RTY_LAST) begin
                        status_n = ST_RTY;
                        state_n  = DONE;
                    end else begin
                        retry_n = retry_cnt + 1'b1;
                        state_n = GAP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    status_n = ST_TMO;
                    state_n  = DONE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            GAP: begin
                tmo_n   = '0;
                state_n = BUS;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Direction bit is kept internally so we_o can drop with cyc_o.
    assign we_n = latch ? cmd_we_i : we_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            we_r      <= 1'b0;
            adr_o     <= '0;
            dat_o     <= '0;
            sel_o     <= '0;
            status_o  <= '0;
            rdata_o   <= '0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= tmo_n;
            retry_cnt <= retry_n;
            status_o  <= status_n;
            rdata_o   <= rdata_n;
            we_r      <= we_n;
            if (latch) begin
                adr_o <= cmd_adr_i;
                dat_o <= cmd_dat_i;
                sel_o <= cmd_sel_i;
            end
            cyc_o  <= (state_n == BUS);
            stb_o  <= (state_n == BUS);
            we_o   <= (state_n == BUS) && we_n;
            busy_o <= (state_n == BUS) || (state_n == GAP);
            done_o <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_tisc_wbvio_master.sv
// Scoreboard bench for tisc_wbvio_master.
// Scripted slave responses; a monitor checks every done_o against the queue.
module tb_tisc_wbvio_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        go_i = 1'b0;
    logic        cmd_we_i = 1'b0;
    logic [20:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        busy_o, done_o;
    logic [1:0]  status_o;
    logic [31:0] rdata_o;
    logic        cyc_o, stb_o, we_o;
    logic [20:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        rty_i = 1'b0;
    logic [31:0] dat_i = '0;

    tisc_wbvio_master #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
        .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .busy_o(busy_o), .done_o(done_o),
        .status_o(status_o), .rdata_o(rdata_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
        .dat_i(dat_i)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err, 5 err+rty
    typedef struct {
        int          dly;
        int          kind;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
        int          b;
        int          c;
        int          g;
    } exp_t;

    resp_t script[$];
    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic push_r(input int dly, input int kind,
                          input logic [31:0] data);
        resp_t r;
        r.dly  = dly;
        r.kind = kind;
        r.data = data;
        script.push_back(r);
    endtask

    // Slave model: drives terminations at negedge from the script.
    initial begin
        resp_t cur;
        bit    active;
        int    cnt;
        active = 0;
        cnt    = 0;
        cur    = '{dly: 0, kind: 0, data: 32'h0};
        forever begin
            @(negedge clk_i);
            ack_i = 1'b0;
            err_i = 1'b0;
            rty_i = 1'b0;
            dat_i = 32'hFFFF_0000;
            if (rst_i || !stb_o) begin
                active = 0;
            end else begin
                if (!active) begin
                    active = 1;
                    cnt    = 0;
                    if (script.size() > 0) cur = script.pop_front();
                    else cur = '{dly: 0, kind: 0, data: 32'h0};
                end
                if (cnt == cur.dly) begin
                    case (cur.kind)
                        1: begin ack_i = 1'b1; dat_i = cur.data; end
                        2: err_i = 1'b1;
                        3: rty_i = 1'b1;
                        4: begin
                            ack_i = 1'b1;
                            err_i = 1'b1;
                            dat_i = cur.data;
                        end
                        5: begin err_i = 1'b1; rty_i = 1'b1; end
                        default: ;
                    endcase
                end
                cnt++;
            end
        end
    end

    // Monitor: counts bursts, stb cycles and gaps; checks on done_o.
    initial begin
        int   bursts, scyc, gaps;
        logic prev_stb;
        exp_t e;
        bursts = 0; scyc = 0; gaps = 0; prev_stb = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                bursts = 0; scyc = 0; gaps = 0; prev_stb = 1'b0;
            end else begin
                if (stb_o && !prev_stb) bursts++;
                if (stb_o) scyc++;
                if (!stb_o && busy_o) gaps++;
                prev_stb = stb_o;
                if ((we_o && !cyc_o) || (stb_o !== cyc_o)) begin
                    chk("we/stb vs cyc", {we_o, stb_o, cyc_o}, 3'b0);
                end
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("status", 32'(status_o), 32'(e.st));
                        chk("rdata", rdata_o, e.rd);
                        chk("bursts", bursts, e.b);
                        chk("stb cycles", scyc, e.c);
                        chk("gap cycles", gaps, e.g);
                        chk("busy at done", 32'(busy_o), 0);
                    end
                    bursts = 0; scyc = 0; gaps = 0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [20:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input bit push, input logic [1:0] st,
                         input logic [31:0] rd, input int b,
                         input int c, input int g);
        exp_t e;
        if (push) begin
            e.st = st; e.rd = rd; e.b = b; e.c = c; e.g = g;
            exp_q.push_back(e);
        end
        cmd_we_i  = we;
        cmd_adr_i = adr;
        cmd_dat_i = dat;
        cmd_sel_i = sel;
        go_i      = 1'b1;
        @(posedge clk_i);
        #1;
        go_i      = 1'b0;
        cmd_we_i  = ~we;
        cmd_adr_i = ~adr;
        cmd_dat_i = ~dat;
        cmd_sel_i = ~sel;
        chk("cyc after go", 32'(cyc_o), 1);
        chk("busy after go", 32'(busy_o), 1);
        chk("adr_o", 32'(adr_o), 32'(adr));
        chk("dat_o", dat_o, dat);
        chk("sel_o", 32'(sel_o), 32'(sel));
        chk("we_o", 32'(we_o), 32'(we));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o) return;
        end
        chk("done timeout", 0, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " cyc"}, 32'(cyc_o), 0);
        chk({nm, " stb"}, 32'(stb_o), 0);
        chk({nm, " we"}, 32'(we_o), 0);
        chk({nm, " busy"}, 32'(busy_o), 0);
        chk({nm, " done"}, 32'(done_o), 0);
        chk({nm, " status"}, 32'(status_o), 0);
        chk({nm, " rdata"}, rdata_o, 0);
        chk({nm, " adr"}, 32'(adr_o), 0);
        chk({nm, " dat"}, dat_o, 0);
        chk({nm, " sel"}, 32'(sel_o), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk_zero("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        push_r(1, 1, 32'hCAFE_F00D);
        issue(1'b1, 21'h000004, 32'hDEAD_BEEF, 4'hF,
              1, 2'b00, 32'h0, 1, 2, 0);
        wait_done();

        // Issued in the DONE cycle: back-to-back command.
        push_r(0, 1, 32'h1234_5678);
        issue(1'b0, 21'h100010, 32'h0, 4'hF,
              1, 2'b00, 32'h1234_5678, 1, 1, 0);
        @(posedge clk_i);
        #1;
        chk("read done latency", 32'(done_o), 1);
        repeat (2) begin @(posedge clk_i); #1; end

        push_r(1, 3, 32'h0);
        push_r(0, 3, 32'h0);
        push_r(2, 1, 32'hA5A5_A5A5);
        issue(1'b0, 21'h000100, 32'h0, 4'hF,
              1, 2'b00, 32'hA5A5_A5A5, 3, 6, 2);
        wait_done();

        repeat (4) push_r(0, 3, 32'h0);
        issue(1'b0, 21'h000200, 32'h0, 4'hF,
              1, 2'b11, 32'hA5A5_A5A5, 4, 4, 3);
        wait_done();

        push_r(0, 0, 32'h0);
        issue(1'b0, 21'h000300, 32'h0, 4'hF,
              1, 2'b10, 32'hA5A5_A5A5, 1, 16, 0);
        wait_done();

        push_r(0, 4, 32'h0BAD_F00D);
        issue(1'b0, 21'h000304, 32'h0, 4'hF,
              1, 2'b00, 32'h0BAD_F00D, 1, 1, 0);
        wait_done();

        push_r(1, 2, 32'h0);
        issue(1'b1, 21'h000308, 32'h5555_AAAA, 4'h3,
              1, 2'b01, 32'h0BAD_F00D, 1, 2, 0);
        wait_done();

        push_r(0, 5, 32'h0);
        issue(1'b0, 21'h00030C, 32'h0, 4'hF,
              1, 2'b01, 32'h0BAD_F00D, 1, 1, 0);
        wait_done();

        push_r(2, 3, 32'h0);
        push_r(0, 1, 32'h1111_2222);
        issue(1'b0, 21'h000310, 32'h0, 4'hC,
              1, 2'b00, 32'h1111_2222, 2, 4, 1);
        wait_done();

        // Reset in the middle of a bus cycle: no completion expected.
        push_r(0, 0, 32'h0);
        issue(1'b0, 21'h0ABCDE, 32'h0, 4'hF,
              0, 2'b00, 32'h0, 0, 0, 0);
        repeat (2) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk_zero("mid-bus reset");
        @(posedge clk_i);
        #1;
        chk("no done after reset", 32'(done_o), 0);

        push_r(0, 1, 32'hCAFE_F00D);
        issue(1'b1, 21'h000020, 32'h0102_0304, 4'h1,
              1, 2'b00, 32'h0, 1, 1, 0);
        wait_done();

        // go_i while busy must be ignored.
        push_r(3, 1, 32'h7654_3210);
        issue(1'b0, 21'h001234, 32'h0, 4'h2,
              1, 2'b00, 32'h7654_3210, 1, 4, 0);
        go_i      = 1'b1;
        cmd_we_i  = 1'b1;
        cmd_adr_i = 21'h1FFFFF;
        @(posedge clk_i);
        #1;
        go_i = 1'b0;
        chk("busy go adr", 32'(adr_o), 32'h001234);
        chk("busy go we", 32'(we_o), 0);
        wait_done();

        repeat (25) begin @(posedge clk_i); #1; end
        chk("idle busy", 32'(busy_o), 0);
        chk("queue drained", exp_q.size(), 0);
        chk("held adr", 32'(adr_o), 32'h001234);
        chk("held status", 32'(status_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
